// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the two-requester UART TX arbiter.
// The grant rule lives here so the top and any future user share one definition.
package uart_arb_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  localparam logic REQ_CPU   = 1'b0;
  localparam logic REQ_DBG   = 1'b1;
  localparam int   DATA_BITS = 8;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
    logic       last;
  } uart_req_t;

  // A held lock pins the grant to its owner; otherwise one valid wins, and a tie goes to rr.
  function automatic logic grant_sel(input logic locked, input logic owner,
                                     input logic rr, input logic v0, input logic v1);
    if (locked)
      return owner;
    if (v0 && v1)
      return rr;
    return v1;
  endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// 8N1 serializer: START, 8 data bits LSB first, STOP, each CLK_DIV cycles long.
// tx is registered and resets high asynchronously, so a reset mid-frame idles the line at once.
module uart_tx_shifter
  import uart_arb_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       tx_o
);

  localparam logic [15:0] CNT_MAX = 16'(CLK_DIV - 1);
  localparam logic [2:0]  IDX_MAX = 3'(DATA_BITS - 1);

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d;
  logic        tx_q, tx_d;
  logic        bit_end;

  assign bit_end = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    if (state_q != IDLE)
      cnt_d = bit_end ? '0 : cnt_q + 16'd1;
    case (state_q)
      IDLE: begin
        if (load_i) begin
          state_d = START;
          cnt_d   = '0;
          idx_d   = '0;
          sh_d    = data_i;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = sh_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_MAX) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            // tx_d looks one bit ahead because sh_q only shifts on this same edge
            idx_d = idx_q + 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
            tx_d  = sh_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end)
          state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == STOP) && bit_end;
  assign tx_o   = tx_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet locking that shares one UART TX line between
// the CPU MMIO UART (port 0) and the debug echo path (port 1).
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int CLK_DIV      = 434,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       tx,
  output logic       busy,
  output logic       owner,
  output logic       locked
);

  localparam bit          TMO_EN   = (LOCK_TIMEOUT != 0);
  localparam logic [15:0] TMO_LAST = 16'(LOCK_TIMEOUT - 1);

  uart_req_t [1:0] req;
  logic [1:0]      rdy;
  logic            gnt, acc, owner_valid;
  logic            sh_busy, sh_done;
  logic            owner_q, owner_d;
  logic            locked_q, locked_d;
  logic            rr_q, rr_d;
  logic [15:0]     tmo_q, tmo_d;

  assign req[0] = {req0_valid, req0_data, req0_last};
  assign req[1] = {req1_valid, req1_data, req1_last};

  assign gnt = grant_sel(locked_q, owner_q, rr_q, req[0].valid, req[1].valid);

  // ready is purely combinational so a requester may drop valid at any time
  for (genvar i = 0; i < 2; i++) begin : g_rdy
    assign rdy[i] = ~sh_busy & req[i].valid & (gnt == 1'(i));
  end

  assign acc         = |rdy;
  assign owner_valid = req[owner_q].valid;

  always_comb begin
    owner_d  = owner_q;
    locked_d = locked_q;
    rr_d     = rr_q;
    tmo_d    = tmo_q;
    if (acc) begin
      owner_d  = gnt;
      locked_d = ~req[gnt].last;
      if (req[gnt].last)
        rr_d = ~gnt;
      tmo_d = '0;
    end else if (sh_done) begin
      tmo_d = '0;
    end else if (TMO_EN && locked_q && !sh_busy && !owner_valid) begin
      // a stalled owner hands the line over as if its packet had ended
      if (tmo_q == TMO_LAST) begin
        locked_d = 1'b0;
        rr_d     = ~owner_q;
        tmo_d    = '0;
      end else begin
        tmo_d = tmo_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= REQ_CPU;
      locked_q <= 1'b0;
      rr_q     <= REQ_CPU;
      tmo_q    <= '0;
    end else begin
      owner_q  <= owner_d;
      locked_q <= locked_d;
      rr_q     <= rr_d;
      tmo_q    <= tmo_d;
    end
  end

  uart_tx_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (acc),
    .data_i (req[gnt].data),
    .busy_o (sh_busy),
    .done_o (sh_done),
    .tx_o   (tx)
  );

  assign req0_ready = rdy[0];
  assign req1_ready = rdy[1];
  assign busy       = sh_busy;
  assign owner      = owner_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table-driven single-byte frames, hand sequences for
// arbitration/lock/timeout/reset, and random packets against a packet-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int CD  = 4;
  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v0 = 1'b0, l0 = 1'b0, v1 = 1'b0, l1 = 1'b0;
  logic [7:0] d0 = '0, d1 = '0;
  logic       ready0, ready1, tx, busy, owner, locked;

  uart_tx_arbiter #(.CLK_DIV(CD), .LOCK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_data(d0), .req0_last(l0), .req0_ready(ready0),
    .req1_valid(v1), .req1_data(d1), .req1_last(l1), .req1_ready(ready1),
    .tx(tx), .busy(busy), .owner(owner), .locked(locked)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // line monitor: decodes frames at mid-bit, checks start and the whole stop bit
  logic [7:0] mon_q[$];
  int         mcnt = -1;
  logic [7:0] msh = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mcnt <= -1;
    end else if (mcnt < 0) begin
      if (tx === 1'b0) mcnt <= 1;
    end else begin
      if (mcnt == CD / 2) chk("start_bit", tx, 0);
      if (mcnt >= CD && mcnt < 9 * CD && (mcnt % CD) == CD / 2) msh[mcnt / CD - 1] <= tx;
      if (mcnt >= 9 * CD) chk("stop_bit", tx, 1);
      if (mcnt == 10 * CD - 1) begin
        mon_q.push_back(msh);
        mcnt <= -1;
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  logic [8:0] q0[$], q1[$];
  int         log_src[$], log_cyc[$], exp_src[$];
  logic [7:0] log_b[$], exp_b[$];

  task automatic clear_logs();
    log_src.delete(); log_cyc.delete(); log_b.delete();
    exp_src.delete(); exp_b.delete(); mon_q.delete();
  endtask

  task automatic do_reset();
    v0 = 0; v1 = 0; l0 = 0; l1 = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_locked", locked, 0);
    chk("rst_ready", {ready0, ready1}, 0);
    rst_n = 1;
    q0.delete(); q1.delete();
    clear_logs();
  endtask

  // Each requester presents its queue head continuously; accepts are logged.
  task automatic drive_queues(input int budget);
    int n = 0;
    logic a0, a1;
    @(posedge clk); #1;
    while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
      v0 = (q0.size() > 0); if (v0) {l0, d0} = q0[0];
      v1 = (q1.size() > 0); if (v1) {l1, d1} = q1[0];
      @(negedge clk);
      a0 = ready0; a1 = ready1;
      if (a0 || a1) chk("one_grant", {a0, a1} == 2'b11, 0);
      if (a0) begin log_src.push_back(0); log_b.push_back(d0); log_cyc.push_back(cyc); end
      if (a1) begin log_src.push_back(1); log_b.push_back(d1); log_cyc.push_back(cyc); end
      @(posedge clk); #1;
      if (a0) void'(q0.pop_front());
      if (a1) void'(q1.pop_front());
      n++;
    end
    v0 = 0; v1 = 0;
    if (n >= budget) chk("drive_timeout", n, 0);
    n = 0;
    while (busy !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) chk("idle_timeout", n, 0);
  endtask

  task automatic check_order(input string tag);
    chk({tag, "_nacc"}, log_src.size(), exp_src.size());
    chk({tag, "_nbytes"}, mon_q.size(), exp_b.size());
    for (int i = 0; i < exp_src.size(); i++) begin
      if (i < log_src.size()) begin
        chk({tag, "_src"}, log_src[i], exp_src[i]);
        chk({tag, "_acc_byte"}, log_b[i], exp_b[i]);
      end
      if (i < mon_q.size()) chk({tag, "_line_byte"}, mon_q[i], exp_b[i]);
    end
  endtask

  typedef struct {
    int         src;
    logic [7:0] data;
    logic       last;
    logic       exp_owner;
    logic       exp_locked;
  } vec_t;

  // One byte from one requester; valid is held through the frame to prove ready stays low.
  task automatic send_one(input vec_t r);
    int  n = 0;
    int  b;
    logic rdy, ebit;
    @(posedge clk); #1;
    if (r.src == 0) begin v0 = 1; d0 = r.data; l0 = r.last; end
    else            begin v1 = 1; d1 = r.data; l1 = r.last; end
    do begin
      @(negedge clk); n++;
      rdy = (r.src == 0) ? ready0 : ready1;
    end while (!rdy && n < 200);
    if (!rdy) chk("tbl_accept_timeout", n, 0);
    @(posedge clk); #1;
    for (int c = 0; c < 10 * CD; c++) begin
      @(negedge clk);
      b = c / CD;
      ebit = (b == 0) ? 1'b0 : (b <= 8) ? r.data[b - 1] : 1'b1;
      chk("tbl_tx", tx, ebit);
      chk("tbl_busy", busy, 1);
      chk("tbl_ready_in_frame", (r.src == 0) ? ready0 : ready1, 0);
      chk("tbl_locked", locked, r.exp_locked);
    end
    @(negedge clk);
    chk("tbl_busy_end", busy, 0);
    chk("tbl_tx_idle", tx, 1);
    chk("tbl_owner", owner, r.exp_owner);
    chk("tbl_ready_idle", (r.src == 0) ? ready0 : ready1, 1);
    v0 = 0; v1 = 0;
  endtask

  task automatic run_random();
    logic [8:0] e0[$], e1[$];
    logic [8:0] b;
    int p0 = 0, p1 = 0, rr = 0, s, len;
    for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
      len = $urandom_range(1, 3);
      for (int j = 0; j < len; j++) e0.push_back({j == len - 1, 8'($urandom)});
    end
    for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
      len = $urandom_range(1, 3);
      for (int j = 0; j < len; j++) e1.push_back({j == len - 1, 8'($urandom)});
    end
    q0 = e0; q1 = e1;
    // packet-level round robin: whole packets, alternate when both have work
    while (p0 < e0.size() || p1 < e1.size()) begin
      if (p0 < e0.size() && p1 < e1.size()) s = rr;
      else s = (p0 < e0.size()) ? 0 : 1;
      do begin
        if (s == 0) begin b = e0[p0]; p0++; end
        else        begin b = e1[p1]; p1++; end
        exp_src.push_back(s); exp_b.push_back(b[7:0]);
      end while (!b[8]);
      rr = 1 - s;
    end
    drive_queues(4000);
    check_order("rand");
  endtask

  vec_t tbl[5];
  int   k;

  initial begin
    tbl[0] = '{0, 8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1, 8'h3C, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{0, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{0, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1, 8'h81, 1'b1, 1'b1, 1'b0};

    do_reset();
    for (int i = 0; i < 5; i++) send_one(tbl[i]);

    // simultaneous requests, then a second pair: rr returns to port 0
    do_reset();
    q0.push_back({1'b1, 8'h11}); q1.push_back({1'b1, 8'h22});
    exp_src.push_back(0); exp_b.push_back(8'h11);
    exp_src.push_back(1); exp_b.push_back(8'h22);
    drive_queues(500);
    check_order("simul1");
    clear_logs();
    q0.push_back({1'b1, 8'h33}); q1.push_back({1'b1, 8'h44});
    exp_src.push_back(0); exp_b.push_back(8'h33);
    exp_src.push_back(1); exp_b.push_back(8'h44);
    drive_queues(500);
    check_order("simul2");

    // packet lock: three-byte packet on port 0 is never interleaved
    do_reset();
    q0.push_back({1'b0, 8'hA1}); q0.push_back({1'b0, 8'hA2}); q0.push_back({1'b1, 8'hA3});
    q1.push_back({1'b1, 8'hB1});
    exp_src.push_back(0); exp_b.push_back(8'hA1);
    exp_src.push_back(0); exp_b.push_back(8'hA2);
    exp_src.push_back(0); exp_b.push_back(8'hA3);
    exp_src.push_back(1); exp_b.push_back(8'hB1);
    drive_queues(1000);
    check_order("lock");
    if (log_cyc.size() >= 4) chk("lock_handover_gap", log_cyc[3] - log_cyc[2], 10 * CD + 1);

    // lock timeout: owner goes silent after a non-last byte
    do_reset();
    @(posedge clk); #1;
    v0 = 1; d0 = 8'h5A; l0 = 0;
    k = 0;
    do begin @(negedge clk); k++; end while (!ready0 && k < 50);
    chk("tmo_first_accept", ready0, 1);
    @(posedge clk); #1;
    v0 = 0; v1 = 1; d1 = 8'h6B; l1 = 1;
    k = 0;
    do begin
      @(negedge clk); k++;
      if (busy) chk("tmo_ready_in_frame", ready1, 0);
    end while (busy && k < 100);
    chk("tmo_locked_at_idle", locked, 1);
    chk("tmo_ready_blocked", ready1, 0);
    k = 0;
    do begin @(negedge clk); k++; end while (!ready1 && k < 100);
    chk("tmo_cycles", k, (k == TMO - 1 || k == TMO + 1) ? k : TMO);
    chk("tmo_locked_fell", locked, 0);
    @(posedge clk); #1;
    v1 = 0;
    @(negedge clk);
    chk("tmo_owner", owner, 1);
    k = 0;
    while (busy && k < 100) begin @(negedge clk); k++; end
    exp_b.push_back(8'h5A); exp_b.push_back(8'h6B);
    chk("tmo_nbytes", mon_q.size(), 2);
    for (int i = 0; i < 2 && i < mon_q.size(); i++) chk("tmo_line_byte", mon_q[i], exp_b[i]);

    // reset mid-frame during data bit 3 (0xC3 bit 3 is 0)
    do_reset();
    @(posedge clk); #1;
    v1 = 1; d1 = 8'hC3; l1 = 0;
    k = 0;
    do begin @(negedge clk); k++; end while (!ready1 && k < 50);
    @(posedge clk); #1;
    v1 = 0;
    repeat (4 + 3 * CD + 2) @(negedge clk);
    chk("midrst_tx_before", tx, 0);
    chk("midrst_owner_before", owner, 1);
    rst_n = 0;
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_owner", owner, 0);
    chk("midrst_locked", locked, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("midrst_no_partial", mon_q.size(), 0);
    q1.push_back({1'b1, 8'h96});
    exp_src.push_back(1); exp_b.push_back(8'h96);
    drive_queues(500);
    check_order("midrst");

    // back-to-back single-byte packets from port 1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q1.push_back({1'b1, 8'(8'h50 + i * 8'h13)});
      exp_src.push_back(1); exp_b.push_back(8'(8'h50 + i * 8'h13));
    end
    drive_queues(1000);
    check_order("b2b");
    for (int i = 1; i < log_cyc.size(); i++) chk("b2b_period", log_cyc[i] - log_cyc[i - 1], 10 * CD + 1);

    for (int r = 0; r < 3; r++) begin
      do_reset();
      run_random();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
